load_store_unit: RTL and testbench

//  Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address.

---
 rtl/load_store_unit.sv | 171 +++++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store stage: one req/gnt/rvalid data-memory transaction per accepted op, with store lane
// steering and load extension. Define LSU_BUS_TIMEOUT_EN to abort stalled bus transactions with Err=11.
module load_store_unit #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        Valid_i,
    output logic        Ready_o,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    input  logic [2:0]  Funct3_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] StoreData_i,
    output logic        Done_o,
    output logic [31:0] LoadData_o,
    output logic [1:0]  Err_o,
    output logic        DmemReq_o,
    output logic [31:0] DmemAddr_o,
    output logic        DmemWe_o,
    output logic [3:0]  DmemBe_o,
    output logic [31:0] DmemWdata_o,
    input  logic        DmemGnt_i,
    input  logic        DmemRvalid_i,
    input  logic [31:0] DmemRdata_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  r_off;
    logic [2:0]  r_f3;
    logic        r_we;
    logic [31:0] r_daddr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_ldata;
    logic [1:0]  r_err;
`ifdef LSU_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;
    logic             w_tmo;
    assign w_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    logic        w_accept;
    logic        w_ill;
    logic        w_misal;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ext;

    assign w_accept = (r_state == S_IDLE) && Valid_i && (MemRead_i || MemWrite_i);
    // Stores only have B/H/W; 011 and 11x are never legal.
    assign w_ill    = (Funct3_i == 3'b011) || (Funct3_i[2:1] == 2'b11) || (MemWrite_i && Funct3_i[2]);
    assign w_misal  = ((Funct3_i[1:0] == 2'b01) && Addr_i[0]) ||
                      ((Funct3_i[1:0] == 2'b10) && (Addr_i[1:0] != 2'b00));

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = StoreData_i;
        case (Funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << Addr_i[1:0];
                w_wdata = {4{StoreData_i[7:0]}};
            end
            2'b01: begin
                w_be    = Addr_i[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{StoreData_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_byte = 8'(DmemRdata_i >> {r_off, 3'b000});
    assign w_half = r_off[1] ? DmemRdata_i[31:16] : DmemRdata_i[15:0];

    always_comb begin
        case (r_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = DmemRdata_i;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_off   <= 2'b00;
            r_f3    <= 3'b000;
            r_we    <= 1'b0;
            r_daddr <= 32'd0;
            r_be    <= 4'd0;
            r_wdata <= 32'd0;
            r_ldata <= 32'd0;
            r_err   <= 2'b00;
`ifdef LSU_BUS_TIMEOUT_EN
            r_cnt   <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_off   <= Addr_i[1:0];
                    r_f3    <= Funct3_i;
                    r_we    <= MemWrite_i;
                    r_daddr <= {Addr_i[31:2], 2'b00};
                    r_be    <= MemWrite_i ? w_be : 4'b1111;
                    r_wdata <= MemWrite_i ? w_wdata : 32'd0;
                    r_ldata <= 32'd0;
`ifdef LSU_BUS_TIMEOUT_EN
                    r_cnt   <= '0;
`endif
                    if (w_ill) begin
                        r_err   <= 2'b10;
                        r_state <= S_RESP;
                    end else if (w_misal) begin
                        r_err   <= 2'b01;
                        r_state <= S_RESP;
                    end else begin
                        r_err   <= 2'b00;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (DmemGnt_i) begin
                        r_state <= r_we ? S_RESP : S_WAIT;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_err   <= 2'b11;
                        r_state <= S_RESP;
                    end
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
                S_WAIT: begin
                    if (DmemRvalid_i) begin
                        r_ldata <= w_ext;
                        r_state <= S_RESP;
                    end
`ifdef LSU_BUS_TIMEOUT_EN
                    else if (w_tmo) begin
                        r_err   <= 2'b11;
                        r_state <= S_RESP;
                    end
                    r_cnt <= r_cnt + 1'b1;
`endif
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign Ready_o     = (r_state == S_IDLE);
    assign Done_o      = (r_state == S_RESP);
    assign DmemReq_o   = (r_state == S_REQ);
    assign DmemWe_o    = (r_state == S_REQ) && r_we;
    assign DmemAddr_o  = r_daddr;
    assign DmemBe_o    = r_be;
    assign DmemWdata_o = r_wdata;
    assign LoadData_o  = r_ldata;
    assign Err_o       = r_err;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected responses, a Done monitor checks them.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        Valid, MemRead, MemWrite;
    logic [2:0]  Funct3;
    logic [31:0] Addr, StoreData;
    logic        DmemGnt, DmemRvalid;
    logic [31:0] DmemRdata;
    logic        Ready_o, Done_o, DmemReq_o, DmemWe_o;
    logic [31:0] LoadData_o, DmemAddr_o, DmemWdata_o;
    logic [1:0]  Err_o;
    logic [3:0]  DmemBe_o;

    load_store_unit #(.TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk), .rst_i(rst), .Valid_i(Valid), .Ready_o(Ready_o),
        .MemRead_i(MemRead), .MemWrite_i(MemWrite), .Funct3_i(Funct3),
        .Addr_i(Addr), .StoreData_i(StoreData), .Done_o(Done_o),
        .LoadData_o(LoadData_o), .Err_o(Err_o), .DmemReq_o(DmemReq_o),
        .DmemAddr_o(DmemAddr_o), .DmemWe_o(DmemWe_o), .DmemBe_o(DmemBe_o),
        .DmemWdata_o(DmemWdata_o), .DmemGnt_i(DmemGnt), .DmemRvalid_i(DmemRvalid),
        .DmemRdata_i(DmemRdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] ld;
        logic [1:0]  err;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (Done_o !== 1'b0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got Done_o=%b, expected 0 (cycle %0d)", Done_o, cyc);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("load_data", LoadData_o, e.ld);
                chk("err", {30'd0, Err_o}, {30'd0, e.err});
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (Ready_o !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", {31'd0, Ready_o}, 32'd1);
    endtask

    // gd = cycles gnt is held low while requesting; rd = cycles from gnt to rvalid.
    task automatic do_op(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input int gd, input int rd, input logic [31:0] rdata,
                         input logic [31:0] exp_ld, input logic [1:0] exp_err,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd);
        exp_t e;
        int t;
        wait_ready();
        Valid = 1'b1; MemRead = !we; MemWrite = we; Funct3 = f3; Addr = a; StoreData = d;
        t = cyc;
        e.ld  = exp_ld;
        e.err = exp_err;
        e.cyc = (exp_err != 2'b00) ? t + 1 : (we ? t + 2 + gd : t + 2 + gd + rd);
        q.push_back(e);
        @(posedge clk); #1;
        Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        if (exp_err != 2'b00) begin
            @(negedge clk);
            chk("err_no_req", {31'd0, DmemReq_o}, 32'd0);
        end else begin
            for (int i = 0; i <= gd; i++) begin
                if (i == gd) DmemGnt = 1'b1;
                @(negedge clk);
                chk("req", {31'd0, DmemReq_o}, 32'd1);
                chk("addr", DmemAddr_o, {a[31:2], 2'b00});
                chk("we", {31'd0, DmemWe_o}, {31'd0, we});
                chk("be", {28'd0, DmemBe_o}, {28'd0, exp_be});
                if (we) chk("wdata", DmemWdata_o, exp_wd);
                @(posedge clk); #1;
                DmemGnt = 1'b0;
            end
            @(negedge clk);
            chk("req_drop", {31'd0, DmemReq_o}, 32'd0);
            if (!we) begin
                for (int i = 1; i < rd; i++) begin
                    @(posedge clk); #1;
                end
                DmemRvalid = 1'b1; DmemRdata = rdata;
                @(posedge clk); #1;
                DmemRvalid = 1'b0; DmemRdata = 32'd0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; Valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b000;
        Addr = 32'd0; StoreData = 32'd0; DmemGnt = 1'b0; DmemRvalid = 1'b0; DmemRdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, Ready_o}, 32'd1);
        chk("rst_done", {31'd0, Done_o}, 32'd0);
        chk("rst_req", {31'd0, DmemReq_o}, 32'd0);
        chk("rst_we", {31'd0, DmemWe_o}, 32'd0);
        chk("rst_err", {30'd0, Err_o}, 32'd0);
        chk("rst_ld", LoadData_o, 32'd0);
        chk("rst_addr", DmemAddr_o, 32'd0);
        chk("rst_be", {28'd0, DmemBe_o}, 32'd0);
        chk("rst_wdata", DmemWdata_o, 32'd0);

        //     we  f3      addr        data         gd rd rdata        exp_ld       err    be       wdata
        do_op(1, 3'b010, 32'h100, 32'hDEADBEEF, 0, 1, 32'h0,        32'h0,        2'b00, 4'b1111, 32'hDEADBEEF);
        do_op(1, 3'b000, 32'h103, 32'h000000A5, 0, 1, 32'h0,        32'h0,        2'b00, 4'b1000, 32'hA5A5A5A5);
        do_op(1, 3'b001, 32'h102, 32'h00001234, 0, 1, 32'h0,        32'h0,        2'b00, 4'b1100, 32'h12341234);
        do_op(1, 3'b000, 32'h100, 32'h0000003C, 1, 1, 32'h0,        32'h0,        2'b00, 4'b0001, 32'h3C3C3C3C);
        do_op(0, 3'b000, 32'h201, 32'h0,        0, 1, 32'h00008000, 32'hFFFFFF80, 2'b00, 4'b1111, 32'h0);
        do_op(0, 3'b100, 32'h201, 32'h0,        0, 1, 32'h00008000, 32'h00000080, 2'b00, 4'b1111, 32'h0);
        do_op(0, 3'b001, 32'h202, 32'h0,        0, 1, 32'hF00D0000, 32'hFFFFF00D, 2'b00, 4'b1111, 32'h0);
        do_op(0, 3'b101, 32'h206, 32'h0,        0, 1, 32'h80010000, 32'h00008001, 2'b00, 4'b1111, 32'h0);
        do_op(0, 3'b010, 32'h302, 32'h0,        0, 1, 32'h0,        32'h0,        2'b01, 4'b1111, 32'h0);
        do_op(1, 3'b001, 32'h101, 32'h0000BEEF, 0, 1, 32'h0,        32'h0,        2'b01, 4'b0011, 32'h0);
        do_op(0, 3'b011, 32'h300, 32'h0,        0, 1, 32'h0,        32'h0,        2'b10, 4'b1111, 32'h0);
        do_op(1, 3'b100, 32'h300, 32'h0,        0, 1, 32'h0,        32'h0,        2'b10, 4'b1111, 32'h0);
        do_op(0, 3'b010, 32'h400, 32'h0,        3, 2, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 4'b1111, 32'h0);

        // Valid with neither direction set must be ignored.
        wait_ready();
        Valid = 1'b1;
        @(posedge clk); #1;
        Valid = 1'b0;
        @(negedge clk);
        chk("ignore_ready", {31'd0, Ready_o}, 32'd1);
        chk("ignore_req", {31'd0, DmemReq_o}, 32'd0);

        // Reset in WAIT, then a stale rvalid: no Done, back in IDLE.
        wait_ready();
        Valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h500;
        @(posedge clk); #1;
        Valid = 1'b0; MemRead = 1'b0; DmemGnt = 1'b1;
        @(posedge clk); #1;
        DmemGnt = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_wait_req", {31'd0, DmemReq_o}, 32'd0);
        DmemRvalid = 1'b1; DmemRdata = 32'h12345678;
        @(posedge clk); #1;
        DmemRvalid = 1'b0; DmemRdata = 32'd0;
        @(negedge clk);
        chk("rst_wait_ready", {31'd0, Ready_o}, 32'd1);
        chk("rst_wait_ld", LoadData_o, 32'd0);

`ifdef LSU_BUS_TIMEOUT_EN
        begin
            exp_t e;
            wait_ready();
            Valid = 1'b1; MemRead = 1'b1; Funct3 = 3'b010; Addr = 32'h600;
            e.ld = 32'd0; e.err = 2'b11; e.cyc = cyc + 65;
            q.push_back(e);
            @(posedge clk); #1;
            Valid = 1'b0; MemRead = 1'b0;
            wait_ready();
            chk("tmo_req", {31'd0, DmemReq_o}, 32'd0);
        end
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
